odd_seq_checker: RTL and testbench

- Sits directly downstream of the day-5 odd counter and consumes its 8-bit count output.
- Checks that every sampled value is odd and equals the previous value + 2, with modulo-2^DATA_W wrap, so 255 is followed by 1.
- Reports lock status, single-cycle error pulses, a sticky error flag, a saturating error count and a saturating wrap count.
- Acts as the self-checking monitor stage for the counter in system benches and on silicon.

---
 rtl/odd_seq_checker.sv | 138 +++++++++++++
 tb/tb_odd_seq_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/odd_seq_checker.sv
// Monitor for the upstream odd counter: checks each sampled value is odd and
// advances by STEP (mod 2^DATA_W). Optional macro ODD_CHK_RESYNC_EN re-locks after a mismatch.
//
// state  | meaning
// S_IDLE | waiting for the first odd sample to establish the expected value
// S_LOCK | tracking; every sample must equal exp_o
// S_ERR  | mismatch seen; samples ignored until clr_i or reset
// S_RSVD | unused encoding, falls back to S_IDLE
module odd_seq_checker #(
  parameter int DATA_W     = 8,
  parameter int STEP       = 2,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [DATA_W-1:0]     cnt_i,
  input  logic                  clr_i,
  output logic                  locked_o,
  output logic                  err_o,
  output logic                  err_sticky_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o,
  output logic [WRAP_CNT_W-1:0] wrap_cnt_o,
  output logic [DATA_W-1:0]     exp_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOCK = 2'd1,
    S_ERR  = 2'd2,
    S_RSVD = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0]     STEP_V   = DATA_W'(STEP);
  localparam logic [DATA_W-1:0]     DATA_MAX = {DATA_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0]  ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [WRAP_CNT_W-1:0] WRAP_MAX = {WRAP_CNT_W{1'b1}};

  state_t                  state_q, state_d;
  logic                    locked_q, locked_d;
  logic                    err_q, err_d;
  logic                    sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [WRAP_CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic [DATA_W-1:0]       exp_q, exp_d;
  logic                    err_event;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    sticky_d   = sticky_q;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    err_event  = 1'b0;

    if (clr_i) begin
      state_d    = S_IDLE;
      exp_d      = '0;
      sticky_d   = 1'b0;
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
    end else if (state_q == S_RSVD) begin
      state_d = S_IDLE;
    end else if (en_i) begin
      case (state_q)
        S_IDLE: begin
          if (cnt_i[0]) begin
            exp_d   = cnt_i + STEP_V;
            state_d = S_LOCK;
          end else begin
            err_event = 1'b1;
          end
        end
        S_LOCK: begin
          if (cnt_i == exp_q) begin
            exp_d = exp_q + STEP_V;
            if (cnt_i == DATA_MAX && wrap_cnt_q != WRAP_MAX)
              wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
          end else begin
            err_event = 1'b1;
`ifdef ODD_CHK_RESYNC_EN
            state_d   = S_IDLE;
`else
            state_d   = S_ERR;
`endif
          end
        end
        S_ERR: begin
`ifdef ODD_CHK_RESYNC_EN
          state_d = S_IDLE;
`else
          state_d = S_ERR;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (err_event) begin
      sticky_d = 1'b1;
      if (err_cnt_q != ERR_MAX)
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
    err_d    = err_event;
    locked_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
      exp_q      <= '0;
    end else begin
      state_q    <= state_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      exp_q      <= exp_d;
    end
  end

  assign locked_o     = locked_q;
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;
  assign err_cnt_o    = err_cnt_q;
  assign wrap_cnt_o   = wrap_cnt_q;
  assign exp_o        = exp_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Bench for odd_seq_checker: directed scenarios plus random stream against a
// behavioural model of the odd/step rules. Honours ODD_CHK_RESYNC_EN.
module tb_odd_seq_checker;

  localparam int DW = 8;
  localparam int MOD = 256;
  localparam int ERR_SAT = 255;
  localparam int WRAP_SAT = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_i;
  logic [7:0]  cnt_i;
  logic        clr_i;
  logic        locked_o, err_o, err_sticky_o;
  logic [7:0]  err_cnt_o;
  logic [15:0] wrap_cnt_o;
  logic [7:0]  exp_o;
  logic [1:0]  state_o;

  int tests = 0;
  int fails = 0;

  // model
  bit m_lock, m_halt, m_sticky, m_err;
  int m_exp, m_errc, m_wrapc;

  odd_seq_checker dut (
    .clk(clk), .reset(reset), .en_i(en_i), .cnt_i(cnt_i), .clr_i(clr_i),
    .locked_o(locked_o), .err_o(err_o), .err_sticky_o(err_sticky_o),
    .err_cnt_o(err_cnt_o), .wrap_cnt_o(wrap_cnt_o), .exp_o(exp_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_lock = 0; m_halt = 0; m_sticky = 0; m_err = 0;
    m_exp = 0; m_errc = 0; m_wrapc = 0;
  endtask

  task automatic model_error();
    m_err = 1;
    m_sticky = 1;
    if (m_errc < ERR_SAT) m_errc++;
  endtask

  task automatic model_apply(input bit en, input bit clr, input int cnt);
    m_err = 0;
    if (clr) model_clear();
    else if (en && !m_halt) begin
      if (!m_lock) begin
        if (cnt % 2 == 1) begin
          m_lock = 1;
          m_exp = (cnt + 2) % MOD;
        end else model_error();
      end else if (cnt == m_exp) begin
        if (cnt == MOD - 1 && m_wrapc < WRAP_SAT) m_wrapc++;
        m_exp = (m_exp + 2) % MOD;
      end else begin
        model_error();
        m_lock = 0;
`ifndef ODD_CHK_RESYNC_EN
        m_halt = 1;
`endif
      end
    end
  endtask

  task automatic check_all(input string ctx);
    int st;
    st = m_halt ? 2 : (m_lock ? 1 : 0);
    chk({ctx, ".locked"}, 32'(locked_o), 32'(m_lock));
    chk({ctx, ".err"}, 32'(err_o), 32'(m_err));
    chk({ctx, ".sticky"}, 32'(err_sticky_o), 32'(m_sticky));
    chk({ctx, ".err_cnt"}, 32'(err_cnt_o), 32'(m_errc));
    chk({ctx, ".wrap_cnt"}, 32'(wrap_cnt_o), 32'(m_wrapc));
    chk({ctx, ".exp"}, 32'(exp_o), 32'(m_exp));
    chk({ctx, ".state"}, 32'(state_o), 32'(st));
  endtask

  task automatic cycle(input bit en, input bit clr, input int cnt, input string ctx);
    en_i = en; clr_i = clr; cnt_i = 8'(cnt);
    @(posedge clk);
    model_apply(en, clr, cnt);
    #1;
    check_all(ctx);
  endtask

  initial begin
    int v;
    int r;
    reset = 1'b1; en_i = 0; clr_i = 0; cnt_i = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all("reset");
    @(negedge clk) reset = 1'b1;

    // clean stream 1..255,1,3
    for (int i = 1; i <= 255; i += 2) cycle(1, 0, i, "clean");
    chk("clean_wrap", 32'(wrap_cnt_o), 32'd1);
    cycle(1, 0, 1, "clean");
    cycle(1, 0, 3, "clean");
    chk("clean_exp_end", 32'(exp_o), 32'd5);
    chk("clean_errcnt", 32'(err_cnt_o), 32'd0);

    // injected fault
    cycle(0, 1, 0, "clr0");
    cycle(1, 0, 1, "fault");
    cycle(1, 0, 3, "fault");
    cycle(1, 0, 7, "fault");
    chk("fault_err_pulse", 32'(err_o), 32'd1);
    cycle(1, 0, 9, "fault");
    chk("fault_err_once", 32'(err_o), 32'd0);
    cycle(1, 0, 11, "fault");
    chk("fault_errcnt", 32'(err_cnt_o), 32'd1);
`ifdef ODD_CHK_RESYNC_EN
    chk("fault_exp_resync", 32'(exp_o), 32'd13);
    chk("fault_state_resync", 32'(state_o), 32'd1);
`else
    chk("fault_state_err", 32'(state_o), 32'd2);
    chk("fault_exp_frozen", 32'(exp_o), 32'd5);
`endif
    cycle(0, 1, 0, "fault_clr");
    chk("fault_clr_state", 32'(state_o), 32'd0);

    // even first sample, then clear priority over sample
    cycle(1, 0, 4, "even");
    chk("even_err", 32'(err_o), 32'd1);
    chk("even_state", 32'(state_o), 32'd0);
    cycle(1, 1, 5, "clrprio");
    chk("clrprio_errcnt", 32'(err_cnt_o), 32'd0);
    chk("clrprio_exp", 32'(exp_o), 32'd0);

    // saturation with even samples (errors in S_IDLE in either build)
    for (int i = 0; i < 300; i++) cycle(1, 0, 2 * $urandom_range(0, 127), "sat");
    chk("sat_errcnt", 32'(err_cnt_o), 32'd255);
    chk("sat_sticky", 32'(err_sticky_o), 32'd1);
    cycle(1, 0, 1, "sat_relock");
    cycle(0, 0, 0, "idle_en0");

    // random stream
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (m_lock && r < 80) v = m_exp;
      else if (!m_lock && r < 60) v = 2 * $urandom_range(0, 127) + 1;
      else v = $urandom_range(0, 255);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, v, "rand");
    end

    // async reset mid-stream
    cycle(0, 1, 0, "pre_async");
    cycle(1, 0, 21, "pre_async");
    cycle(1, 0, 23, "pre_async");
    chk("pre_async_locked", 32'(locked_o), 32'd1);
    en_i = 0;
    #2 reset = 1'b0;
    #1 model_clear();
    check_all("async");
    @(negedge clk) reset = 1'b1;
    cycle(1, 0, 1, "post_async");
    chk("post_async_locked", 32'(locked_o), 32'd1);
    chk("post_async_exp", 32'(exp_o), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
